// File: rtl/nn_sample_sequencer_if.sv
// rtl/nn_sample_sequencer_if.sv - sample, control and result bundle between the sequencer and the NeuralNetwork
// master = sequencer side, slave = network/host side.
interface nn_sample_sequencer_if #(
  parameter int EPOCH_W = 16
);
  logic               start;
  logic               x_out;
  logic               y_out;
  logic               test_flag;
  logic               nn_reset;
  logic               nn_reset_value;
  logic [1:0]         predicted;
  logic [1:0]         expected;
  logic [1:0]         sample_idx;
  logic [EPOCH_W-1:0] epoch_count;
  logic [2:0]         correct_count;
  logic               busy;
  logic               done;
  logic               pass;
  logic               error;

  modport master (
    input  start, predicted, expected,
    output x_out, y_out, test_flag, nn_reset, nn_reset_value,
           sample_idx, epoch_count, correct_count, busy, done, pass, error
  );

  modport slave (
    output start, predicted, expected,
    input  x_out, y_out, test_flag, nn_reset, nn_reset_value,
           sample_idx, epoch_count, correct_count, busy, done, pass, error
  );
endinterface

// File: rtl/nn_sample_sequencer.sv
// rtl/nn_sample_sequencer.sv - XOR train/test stimulus and scoring controller for the NeuralNetwork block
// Optional NN_SEQ_SHUFFLE_EN: per-epoch LFSR pattern shuffle during training.
module nn_sample_sequencer #(
  parameter int SAMPLE_CYCLES = 8,
  parameter int NUM_EPOCHS    = 1000,
  parameter int EPOCH_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  nn_sample_sequencer_if.master bus
);
  localparam int                 CNT_W      = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(NUM_EPOCHS);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_TRAIN, S_TEST, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [1:0]         r_idx, w_idx_next;
  logic [EPOCH_W-1:0] r_epoch, w_epoch_next;
  logic [2:0]         r_correct, w_correct_next;
  logic               r_error, w_error_next;

  logic r_x, r_y, r_test, r_nn_reset, r_nn_reset_value, r_busy, r_done, r_pass;
  logic w_x_next, w_y_next, w_test_next, w_nn_reset_next, w_nn_reset_value_next;
  logic w_busy_next, w_done_next, w_pass_next;

  logic       w_wrap;
  logic       w_epoch_done;
  logic [1:0] w_xor_code;
  logic [1:0] w_mask;
  logic [1:0] w_order_next;

  assign w_wrap       = (r_cnt == CNT_LAST);
  assign w_epoch_done = (r_state == S_TRAIN) && w_wrap && (r_idx == 2'd3);
  assign w_xor_code   = {r_idx[1] ^ r_idx[0], ~(r_idx[1] ^ r_idx[0])};

`ifdef NN_SEQ_SHUFFLE_EN
  logic [7:0] r_lfsr, w_lfsr_next;

  always_comb begin
    w_lfsr_next = r_lfsr;
    if (r_state == S_INIT) begin
      w_lfsr_next = 8'hA5;
    end else if (w_epoch_done) begin
      w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= 8'hA5;
    else       r_lfsr <= w_lfsr_next;
  end

  // Shuffle only training; the test pass always walks 00,01,10,11.
  assign w_mask = (w_state_next == S_TRAIN) ? w_lfsr_next[1:0] : 2'b00;
`else
  assign w_mask = 2'b00;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_idx_next     = r_idx;
    w_epoch_next   = r_epoch;
    w_correct_next = r_correct;
    w_error_next   = r_error;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_next = S_INIT;
      end
      S_INIT: begin
        w_cnt_next     = '0;
        w_idx_next     = 2'd0;
        w_epoch_next   = '0;
        w_correct_next = 3'd0;
        w_error_next   = 1'b0;
        w_state_next   = S_TRAIN;
      end
      S_TRAIN: begin
        w_cnt_next = w_wrap ? '0 : r_cnt + CNT_W'(1);
        if (w_wrap) begin
          w_idx_next = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_epoch_next = r_epoch + EPOCH_W'(1);
            if (w_epoch_next == EPOCH_LAST) w_state_next = S_TEST;
          end
        end
      end
      S_TEST: begin
        w_cnt_next = w_wrap ? '0 : r_cnt + CNT_W'(1);
        if (w_wrap) begin
          w_idx_next = r_idx + 2'd1;
          if ((bus.predicted == bus.expected) && (bus.predicted != 2'b00)) begin
            w_correct_next = r_correct + 3'd1;
          end
          if (bus.expected != w_xor_code) w_error_next = 1'b1;
          if (r_idx == 2'd3) w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) w_state_next = S_INIT;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    w_order_next          = w_idx_next ^ w_mask;
    w_x_next              = 1'b0;
    w_y_next              = 1'b0;
    w_test_next           = 1'b0;
    w_nn_reset_next       = 1'b1;
    w_nn_reset_value_next = 1'b0;
    w_busy_next           = 1'b0;
    w_done_next           = 1'b0;
    w_pass_next           = 1'b0;
    case (w_state_next)
      S_INIT: begin
        w_nn_reset_value_next = 1'b1;
        w_busy_next           = 1'b1;
      end
      S_TRAIN, S_TEST: begin
        w_x_next        = w_order_next[1];
        w_y_next        = w_order_next[0];
        w_test_next     = (w_state_next == S_TEST);
        w_nn_reset_next = 1'b0;
        w_busy_next     = 1'b1;
      end
      S_DONE: begin
        w_done_next = 1'b1;
        w_pass_next = (w_correct_next == 3'd4);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_idx            <= 2'd0;
      r_epoch          <= '0;
      r_correct        <= 3'd0;
      r_error          <= 1'b0;
      r_x              <= 1'b0;
      r_y              <= 1'b0;
      r_test           <= 1'b0;
      r_nn_reset       <= 1'b1;
      r_nn_reset_value <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_cnt            <= w_cnt_next;
      r_idx            <= w_idx_next;
      r_epoch          <= w_epoch_next;
      r_correct        <= w_correct_next;
      r_error          <= w_error_next;
      r_x              <= w_x_next;
      r_y              <= w_y_next;
      r_test           <= w_test_next;
      r_nn_reset       <= w_nn_reset_next;
      r_nn_reset_value <= w_nn_reset_value_next;
      r_busy           <= w_busy_next;
      r_done           <= w_done_next;
      r_pass           <= w_pass_next;
    end
  end

  assign bus.x_out          = r_x;
  assign bus.y_out          = r_y;
  assign bus.test_flag      = r_test;
  assign bus.nn_reset       = r_nn_reset;
  assign bus.nn_reset_value = r_nn_reset_value;
  assign bus.sample_idx     = r_idx;
  assign bus.epoch_count    = r_epoch;
  assign bus.correct_count  = r_correct;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.error          = r_error;
endmodule

// File: tb/tb_nn_sample_sequencer.sv
// tb/tb_nn_sample_sequencer.sv - self-checking bench for nn_sample_sequencer
// Expected waveforms come from a per-cycle schedule of the run; define NN_SEQ_SHUFFLE_EN to match a shuffled build.
module tb_nn_sample_sequencer;
  localparam int SC     = 8;
  localparam int NE     = 2;
  localparam int EW     = 16;
  localparam int T_TEST = 2 + NE * 4 * SC;
  localparam int T_DONE = 2 + (NE + 1) * 4 * SC;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [1:0] pred_code  [4];
  logic [1:0] exp_code   [4];
  logic [1:0] epoch_mask [NE];

  nn_sample_sequencer_if #(.EPOCH_W(EW)) bus ();

  nn_sample_sequencer #(
    .SAMPLE_CYCLES(SC),
    .NUM_EPOCHS   (NE),
    .EPOCH_W      (EW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [1:0] xor_code(input logic [1:0] pat);
    return {pat[1] ^ pat[0], ~(pat[1] ^ pat[0])};
  endfunction

  task automatic build_masks();
    logic [7:0] m;
    m = 8'hA5;
    for (int e = 0; e < NE; e++) begin
`ifdef NN_SEQ_SHUFFLE_EN
      epoch_mask[e] = m[1:0];
`else
      epoch_mask[e] = 2'b00;
`endif
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end
  endtask

  task automatic set_ideal_codes();
    for (int i = 0; i < 4; i++) begin
      pred_code[i] = xor_code(2'(i));
      exp_code[i]  = xor_code(2'(i));
    end
  endtask

  // One full run from a start pulse; t counts cycles after the start edge.
  task automatic run_and_check(input int glitch_t, input int reset_t);
    int         e, s, u;
    int         want_correct;
    logic       want_error;
    logic [1:0] pat;
    logic [6:0] want_ctl, got_ctl;
    logic [1:0] want_idx;
    logic [EW-1:0] want_ep;
    want_correct = 0;
    want_error   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pred_code[i] == exp_code[i] && pred_code[i] != 2'b00) want_correct++;
      if (exp_code[i] != xor_code(2'(i))) want_error = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= T_DONE; t++) begin
      @(negedge clk);
      bus.start     = (t == glitch_t);
      bus.predicted = 2'b00;
      bus.expected  = 2'b00;
      // ctl = {x, y, test_flag, nn_reset, nn_reset_value, busy, done}
      if (t == 1) begin
        want_ctl = 7'b0001110;
        want_idx = 2'd0;
        want_ep  = '0;
      end else if (t < T_TEST) begin
        u        = t - 2;
        e        = u / (4 * SC);
        s        = (u / SC) % 4;
        pat      = 2'(s) ^ epoch_mask[e];
        want_ctl = {pat, 5'b00010};
        want_idx = 2'(s);
        want_ep  = EW'(e);
      end else if (t < T_DONE) begin
        u        = t - T_TEST;
        s        = u / SC;
        pat      = 2'(s);
        want_ctl = {pat, 5'b10010};
        want_idx = 2'(s);
        want_ep  = EW'(NE);
        bus.predicted = pred_code[s];
        bus.expected  = exp_code[s];
      end else begin
        want_ctl = 7'b0001001;
        want_idx = 2'd0;
        want_ep  = EW'(NE);
      end
      got_ctl = {bus.x_out, bus.y_out, bus.test_flag, bus.nn_reset,
                 bus.nn_reset_value, bus.busy, bus.done};
      n_checks++;
      if (got_ctl !== want_ctl) begin
        n_errors++;
        $display("FAIL ctl t=%0d x,y,tf,nr,nrv,busy,done got %b want %b", t, got_ctl, want_ctl);
      end
      if (t >= 2) begin
        n_checks++;
        if (bus.sample_idx !== want_idx || bus.epoch_count !== want_ep) begin
          n_errors++;
          $display("FAIL counters t=%0d idx/epoch got %0d/%0d want %0d/%0d",
                   t, bus.sample_idx, bus.epoch_count, want_idx, want_ep);
        end
      end
      if (t == 2) begin
        n_checks++;
        if (bus.correct_count !== 3'd0 || bus.error !== 1'b0) begin
          n_errors++;
          $display("FAIL init_clear correct/error got %0d/%b want 0/0", bus.correct_count, bus.error);
        end
      end
      if (t == T_DONE) begin
        n_checks++;
        if (bus.correct_count !== 3'(want_correct) || bus.pass !== (want_correct == 4) ||
            bus.error !== want_error) begin
          n_errors++;
          $display("FAIL result correct/pass/error got %0d/%b/%b want %0d/%b/%b",
                   bus.correct_count, bus.pass, bus.error, want_correct, (want_correct == 4), want_error);
        end
      end
      if (t == reset_t) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.nn_reset !== 1'b1 || bus.nn_reset_value !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_nn nr/nrv got %b/%b want 1/0", bus.nn_reset, bus.nn_reset_value);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0 || bus.error !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags busy/done/pass/error got %b%b%b%b want 0000",
               bus.busy, bus.done, bus.pass, bus.error);
    end
    n_checks++;
    if (bus.sample_idx !== 2'd0 || bus.epoch_count !== '0 || bus.correct_count !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_counters idx/epoch/correct got %0d/%0d/%0d want 0/0/0",
               bus.sample_idx, bus.epoch_count, bus.correct_count);
    end
    n_checks++;
    if ({bus.x_out, bus.y_out, bus.test_flag} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_samples x,y,tf got %b want 000", {bus.x_out, bus.y_out, bus.test_flag});
    end
  endtask

  task automatic test_ideal();
    set_ideal_codes();
    run_and_check(0, 0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.correct_count !== 3'd4) begin
      n_errors++;
      $display("FAIL ideal_hold done/pass/correct got %b/%b/%0d want 1/1/4",
               bus.done, bus.pass, bus.correct_count);
    end
  endtask

  task automatic test_forced_predicted();
    set_ideal_codes();
    for (int i = 0; i < 4; i++) pred_code[i] = 2'b01;
    run_and_check(0, 0);
  endtask

  task automatic test_expected_error();
    set_ideal_codes();
    exp_code[1] = 2'b00;
    run_and_check(0, 0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.error !== 1'b1 || bus.done !== 1'b1) begin
      n_errors++;
      $display("FAIL error_sticky error/done got %b/%b want 1/1", bus.error, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    set_ideal_codes();
    run_and_check(0, 0);
  endtask

  task automatic test_random();
    for (int iter = 0; iter < 4; iter++) begin
      for (int i = 0; i < 4; i++) begin
        pred_code[i] = 2'($urandom_range(0, 3));
        exp_code[i]  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : xor_code(2'(i));
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_and_check(0, 0);
    end
  endtask

  task automatic test_reset_midrun();
    int glitch_t, reset_t;
    set_ideal_codes();
    glitch_t = 2 + $urandom_range(0, 4 * SC - 1);
    reset_t  = 2 + 4 * SC + 2 * SC + $urandom_range(0, SC - 1);
    run_and_check(glitch_t, reset_t);
    n_checks++;
    if ({bus.x_out, bus.y_out} !== 2'b00 || bus.epoch_count !== '0 || bus.sample_idx !== 2'd0) begin
      n_errors++;
      $display("FAIL midrun_reset x,y/epoch/idx got %b/%0d/%0d want 00/0/0",
               {bus.x_out, bus.y_out}, bus.epoch_count, bus.sample_idx);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.nn_reset !== 1'b1 || bus.test_flag !== 1'b0) begin
      n_errors++;
      $display("FAIL midrun_ctl busy/nr/tf got %b/%b/%b want 0/1/0", bus.busy, bus.nn_reset, bus.test_flag);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.nn_reset_value !== 1'b0) begin
      n_errors++;
      $display("FAIL midrun_idle busy/done/nrv got %b/%b/%b want 0/0/0",
               bus.busy, bus.done, bus.nn_reset_value);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.predicted = 2'b00;
    bus.expected  = 2'b00;
    build_masks();
    test_reset();
    test_ideal();
    test_forced_predicted();
    test_expected_error();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    test_ideal();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
